// File: rtl/ace_ccu_conflict_tracker_pkg.sv
// Shared types and width helpers for the CCU snoop conflict tracker.
// Widths depending on module parameters are derived with ct_width().
package ace_ccu_conflict_tracker_pkg;

    localparam int unsigned CtDefaultAddrWidth = 8;

    typedef logic [CtDefaultAddrWidth-1:0] cm_idx_t;

    // Bits needed to encode n distinct values, never less than one.
    function automatic int unsigned ct_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ace_ccu_conflict_tracker_entry.sv
// One tracking-table slot: holds valid/addr/owner/count, reports address matches.
// Latency: matches are combinational from registered state; updates land at the next edge.
// Backpressure: none here; the top decides stalls and feeds inc/dec/alloc.
module ace_ccu_conflict_tracker_entry
    import ace_ccu_conflict_tracker_pkg::*;
#(
    parameter int unsigned NumSnoopPorts = 2,
    parameter int unsigned NumRespPorts  = 4,
    parameter int unsigned CmAddrWidth   = CtDefaultAddrWidth,
    parameter int unsigned OwnerWidth    = ct_width(NumSnoopPorts),
    parameter int unsigned CntWidth      = ct_width(9),
    parameter int unsigned DecWidth      = ct_width(NumRespPorts + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumSnoopPorts*CmAddrWidth-1:0]  snp_addr_i,
    input  logic [NumRespPorts-1:0]               rel_valid_i,
    input  logic [NumRespPorts*CmAddrWidth-1:0]   rel_addr_i,
    input  logic                                  inc_i,
    input  logic [DecWidth-1:0]                   dec_cnt_i,
    input  logic                                  alloc_i,
    input  logic [CmAddrWidth-1:0]                alloc_addr_i,
    input  logic [OwnerWidth-1:0]                 alloc_owner_i,
    output logic [NumSnoopPorts-1:0]              snp_match_o,
    output logic [NumRespPorts-1:0]               rel_match_o,
    output logic                                  valid_o,
    output logic [OwnerWidth-1:0]                 owner_o,
    output logic [CntWidth-1:0]                   count_o,
    output logic                                  underflow_o
);

    typedef struct packed {
        logic                   valid;
        logic [CmAddrWidth-1:0] addr;
        logic [OwnerWidth-1:0]  owner;
        logic [CntWidth-1:0]    count;
    } ct_entry_t;

    localparam int unsigned SumWidth = ((CntWidth > DecWidth) ? CntWidth : DecWidth) + 1;

    ct_entry_t             ent_q, ent_d;
    logic [SumWidth-1:0]   total;
    logic [SumWidth-1:0]   dec_ext;

    always_comb begin
        snp_match_o = '0;
        rel_match_o = '0;
        for (int k = 0; k < NumSnoopPorts; k++) begin
            snp_match_o[k] = ent_q.valid && (ent_q.addr == snp_addr_i[k*CmAddrWidth +: CmAddrWidth]);
        end
        for (int j = 0; j < NumRespPorts; j++) begin
            rel_match_o[j] = rel_valid_i[j] && ent_q.valid &&
                             (ent_q.addr == rel_addr_i[j*CmAddrWidth +: CmAddrWidth]);
        end
    end

    // Increment and decrement net out; over-release frees the slot and flags underflow.
    always_comb begin
        ent_d       = ent_q;
        underflow_o = 1'b0;
        total       = SumWidth'(ent_q.count) + SumWidth'(inc_i);
        dec_ext     = SumWidth'(dec_cnt_i);
        if (alloc_i) begin
            ent_d.valid = 1'b1;
            ent_d.addr  = alloc_addr_i;
            ent_d.owner = alloc_owner_i;
            ent_d.count = CntWidth'(1);
        end else if (ent_q.valid) begin
            if (dec_ext > total) begin
                underflow_o = 1'b1;
                ent_d.valid = 1'b0;
                ent_d.count = '0;
            end else if (dec_ext == total) begin
                ent_d.valid = 1'b0;
                ent_d.count = '0;
            end else begin
                ent_d.count = CntWidth'(total - dec_ext);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign valid_o = ent_q.valid;
    assign owner_o = ent_q.owner;
    assign count_o = ent_q.count;

endmodule

// File: rtl/ace_ccu_conflict_tracker.sv
// Tracks in-flight snoops per line index across several snoop ports; optional stats via ACE_CCU_CONFLICT_TRACKER_STATS_EN.
// Latency: stall is zero-cycle (registered table + same-cycle snoops); table updates at the next edge.
// Backpressure: snp_stall_o holds a snoop on owner conflict, per-entry saturation or a full table.
module ace_ccu_conflict_tracker
    import ace_ccu_conflict_tracker_pkg::*;
#(
    parameter int unsigned NumSnoopPorts = 2,
    parameter int unsigned NumRespPorts  = 4,
    parameter int unsigned NumEntries    = 8,
    parameter int unsigned CmAddrWidth   = CtDefaultAddrWidth,
    parameter int unsigned MaxCount      = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumSnoopPorts-1:0]              snp_valid_i,
    input  logic [NumSnoopPorts*CmAddrWidth-1:0]  snp_addr_i,
    output logic [NumSnoopPorts-1:0]              snp_stall_o,
    input  logic [NumRespPorts-1:0]               rel_valid_i,
    input  logic [NumRespPorts*CmAddrWidth-1:0]   rel_addr_i,
    output logic [$clog2(NumEntries+1)-1:0]       occupancy_o,
    output logic                                  full_o,
    output logic                                  err_o
`ifdef ACE_CCU_CONFLICT_TRACKER_STATS_EN
    ,
    output logic [31:0]                           stall_cycles_o,
    output logic [$clog2(NumEntries+1)-1:0]       peak_occ_o
`endif
);

    localparam int unsigned OwnerWidth = ct_width(NumSnoopPorts);
    localparam int unsigned CntWidth   = ct_width(MaxCount + 1);
    localparam int unsigned DecWidth   = ct_width(NumRespPorts + 1);
    localparam int unsigned OccWidth   = $clog2(NumEntries + 1);

    logic [NumSnoopPorts-1:0] snp_match   [NumEntries];
    logic [NumRespPorts-1:0]  rel_match   [NumEntries];
    logic [OwnerWidth-1:0]    ent_owner   [NumEntries];
    logic [CntWidth-1:0]      ent_count   [NumEntries];
    logic [DecWidth-1:0]      dec_cnt     [NumEntries];
    logic [CmAddrWidth-1:0]   alloc_addr  [NumEntries];
    logic [OwnerWidth-1:0]    alloc_owner [NumEntries];
    logic [NumEntries-1:0]    ent_valid, underflow, inc, alloc, free, pick;
    logic [NumSnoopPorts-1:0] accepted;
    logic [NumRespPorts-1:0]  rel_hit;
    logic                     hit, conflict;
    logic                     err_q, err_d;
    logic [OccWidth-1:0]      occ_cnt;

    for (genvar e = 0; e < NumEntries; e++) begin : g_entry
        ace_ccu_conflict_tracker_entry #(
            .NumSnoopPorts (NumSnoopPorts),
            .NumRespPorts  (NumRespPorts),
            .CmAddrWidth   (CmAddrWidth),
            .OwnerWidth    (OwnerWidth),
            .CntWidth      (CntWidth),
            .DecWidth      (DecWidth)
        ) u_entry (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .snp_addr_i    (snp_addr_i),
            .rel_valid_i   (rel_valid_i),
            .rel_addr_i    (rel_addr_i),
            .inc_i         (inc[e]),
            .dec_cnt_i     (dec_cnt[e]),
            .alloc_i       (alloc[e]),
            .alloc_addr_i  (alloc_addr[e]),
            .alloc_owner_i (alloc_owner[e]),
            .snp_match_o   (snp_match[e]),
            .rel_match_o   (rel_match[e]),
            .valid_o       (ent_valid[e]),
            .owner_o       (ent_owner[e]),
            .count_o       (ent_count[e]),
            .underflow_o   (underflow[e])
        );
    end

    // Ports resolved in index order; lower ports consume free slots first.
    always_comb begin
        snp_stall_o = '0;
        inc         = '0;
        alloc       = '0;
        accepted    = '0;
        free        = ~ent_valid;
        pick        = '0;
        hit         = 1'b0;
        conflict    = 1'b0;
        for (int e = 0; e < NumEntries; e++) begin
            alloc_addr[e]  = '0;
            alloc_owner[e] = '0;
        end
        for (int k = 0; k < NumSnoopPorts; k++) begin
            hit      = 1'b0;
            conflict = 1'b0;
            for (int e = 0; e < NumEntries; e++) begin
                if (snp_valid_i[k] && snp_match[e][k]) begin
                    hit = 1'b1;
                    if (ent_owner[e] != OwnerWidth'(k) || ent_count[e] >= CntWidth'(MaxCount)) begin
                        snp_stall_o[k] = 1'b1;
                    end else begin
                        inc[e] = 1'b1;
                    end
                end
            end
            for (int j = 0; j < k; j++) begin
                if (accepted[j] && snp_addr_i[j*CmAddrWidth +: CmAddrWidth] ==
                                   snp_addr_i[k*CmAddrWidth +: CmAddrWidth]) begin
                    conflict = 1'b1;
                end
            end
            pick = free & (~free + NumEntries'(1));
            if (snp_valid_i[k] && !hit) begin
                if (pick == '0 || conflict) begin
                    snp_stall_o[k] = 1'b1;
                end else begin
                    alloc = alloc | pick;
                    free  = free & ~pick;
                    for (int e = 0; e < NumEntries; e++) begin
                        if (pick[e]) begin
                            alloc_addr[e]  = snp_addr_i[k*CmAddrWidth +: CmAddrWidth];
                            alloc_owner[e] = OwnerWidth'(k);
                        end
                    end
                end
            end
            accepted[k] = snp_valid_i[k] & ~snp_stall_o[k];
        end
    end

    always_comb begin
        rel_hit = '0;
        occ_cnt = '0;
        for (int e = 0; e < NumEntries; e++) begin
            dec_cnt[e] = '0;
            for (int j = 0; j < NumRespPorts; j++) begin
                dec_cnt[e] = dec_cnt[e] + DecWidth'(rel_match[e][j]);
            end
            rel_hit = rel_hit | rel_match[e];
            occ_cnt = occ_cnt + OccWidth'(ent_valid[e]);
        end
        err_d = err_q | (|underflow) | (|(rel_valid_i & ~rel_hit));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign occupancy_o = occ_cnt;
    assign full_o      = (occ_cnt == OccWidth'(NumEntries));
    assign err_o       = err_q;

`ifdef ACE_CCU_CONFLICT_TRACKER_STATS_EN
    logic [31:0]         stall_cycles_q, stall_cycles_d;
    logic [OccWidth-1:0] peak_occ_q, peak_occ_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((|snp_stall_o) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        peak_occ_d = (occ_cnt > peak_occ_q) ? occ_cnt : peak_occ_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            peak_occ_q     <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            peak_occ_q     <= peak_occ_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign peak_occ_o     = peak_occ_q;
`endif

endmodule

// File: tb/tb_ace_ccu_conflict_tracker.sv
// Bench for ace_ccu_conflict_tracker: directed scenarios plus random traffic
// checked against a per-line (address -> owner, count) reference model.
module tb_ace_ccu_conflict_tracker;

    localparam int NE = 8;
    localparam int MC = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  snp_valid_i = '0;
    logic [15:0] snp_addr_i = '0;
    logic [1:0]  snp_stall_o;
    logic [3:0]  rel_valid_i = '0;
    logic [31:0] rel_addr_i = '0;
    logic [3:0]  occupancy_o;
    logic        full_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    ace_ccu_conflict_tracker dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .snp_valid_i (snp_valid_i),
        .snp_addr_i  (snp_addr_i),
        .snp_stall_o (snp_stall_o),
        .rel_valid_i (rel_valid_i),
        .rel_addr_i  (rel_addr_i),
        .occupancy_o (occupancy_o),
        .full_o      (full_o),
        .err_o       (err_o)
    );

    int checks = 0;
    int failures = 0;

    int   m_cnt[int];
    int   m_own[int];
    bit   m_err = 1'b0;

    logic [1:0] obs_stall, exp_stall;
    int         obs_occ;
    logic       obs_full, obs_err;

    // Drive one cycle, predict stalls from the model, clock, then advance the model.
    task automatic step(input logic r, input logic [1:0] sv, input logic [15:0] sa,
                        input logic [3:0] rv, input logic [31:0] ra);
        int acc_addr[$];
        int acc_port[$];
        int inc[int];
        int dec[int];
        int keys[$];
        int nalloc, a, tot, d;
        bit conflict;
        rst_i = r; snp_valid_i = sv; snp_addr_i = sa; rel_valid_i = rv; rel_addr_i = ra;
        #1;
        obs_stall = snp_stall_o;
        exp_stall = '0;
        nalloc = 0;
        for (int k = 0; k < 2; k++) begin
            if (!sv[k]) continue;
            a = int'(sa[k*8 +: 8]);
            if (m_cnt.exists(a)) begin
                if (m_own[a] != k || m_cnt[a] >= MC) exp_stall[k] = 1'b1;
            end else begin
                conflict = 1'b0;
                foreach (acc_addr[i]) if (acc_addr[i] == a) conflict = 1'b1;
                if (m_cnt.num() + nalloc >= NE || conflict) exp_stall[k] = 1'b1;
                else nalloc++;
            end
            if (!exp_stall[k]) begin
                acc_addr.push_back(a);
                acc_port.push_back(k);
            end
        end
        @(posedge clk_i);
        if (r) begin
            m_cnt.delete();
            m_own.delete();
            m_err = 1'b0;
        end else begin
            foreach (acc_addr[i]) begin
                a = acc_addr[i];
                if (m_cnt.exists(a)) inc[a] = 1;
            end
            for (int j = 0; j < 4; j++) begin
                if (!rv[j]) continue;
                a = int'(ra[j*8 +: 8]);
                if (m_cnt.exists(a)) dec[a] = (dec.exists(a) ? dec[a] : 0) + 1;
                else m_err = 1'b1;
            end
            foreach (m_cnt[key]) keys.push_back(key);
            foreach (keys[i]) begin
                a = keys[i];
                tot = m_cnt[a] + (inc.exists(a) ? inc[a] : 0);
                d = dec.exists(a) ? dec[a] : 0;
                if (d > tot) m_err = 1'b1;
                if (d >= tot) begin
                    m_cnt.delete(a);
                    m_own.delete(a);
                end else begin
                    m_cnt[a] = tot - d;
                end
            end
            foreach (acc_addr[i]) begin
                if (!m_cnt.exists(acc_addr[i])) begin
                    m_cnt[acc_addr[i]] = 1;
                    m_own[acc_addr[i]] = acc_port[i];
                end
            end
        end
        #1;
        obs_occ = int'(occupancy_o);
        obs_full = full_o;
        obs_err = err_o;
    endtask

    task automatic test_reset();
        step(1'b1, 2'b11, {8'h02, 8'h01}, 4'h0, 32'h0);
        checks++; if (obs_occ !== 0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", obs_occ); end
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", obs_err); end
        checks++; if (obs_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", obs_full); end
        step(1'b1, 2'b11, {8'h02, 8'h01}, 4'h0, 32'h0);
        checks++; if (obs_stall !== 2'b00) begin failures++; $display("FAIL reset_stall got=%b exp=00", obs_stall); end
        step(1'b0, 2'b00, 16'h0, 4'h0, 32'h0);
    endtask

    task automatic test_owner_conflict();
        step(1'b1, 2'b00, 16'h0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01, {8'h00, 8'h12}, 4'h0, 32'h0);
            checks++; if (obs_stall !== 2'b00) begin failures++; $display("FAIL own_p0_accept i=%0d got=%b exp=00", i, obs_stall); end
        end
        step(1'b0, 2'b10, {8'h12, 8'h00}, 4'h0, 32'h0);
        checks++; if (obs_stall !== 2'b10) begin failures++; $display("FAIL own_p1_stall got=%b exp=10", obs_stall); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b10, {8'h12, 8'h00}, 4'b0001, 32'h12);
            checks++; if (obs_stall !== 2'b10) begin failures++; $display("FAIL own_rel_stall i=%0d got=%b exp=10", i, obs_stall); end
        end
        checks++; if (obs_occ !== 0) begin failures++; $display("FAIL own_freed_occ got=%0d exp=0", obs_occ); end
        step(1'b0, 2'b10, {8'h12, 8'h00}, 4'h0, 32'h0);
        checks++; if (obs_stall !== 2'b00) begin failures++; $display("FAIL own_p1_after got=%b exp=00", obs_stall); end
        checks++; if (obs_occ !== 1) begin failures++; $display("FAIL own_p1_occ got=%0d exp=1", obs_occ); end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 2'b00, 16'h0, 4'h0, 32'h0);
        step(1'b0, 2'b11, {8'h40, 8'h40}, 4'h0, 32'h0);
        checks++; if (obs_stall !== 2'b10) begin failures++; $display("FAIL same_stall got=%b exp=10", obs_stall); end
        checks++; if (obs_occ !== 1) begin failures++; $display("FAIL same_occ got=%0d exp=1", obs_occ); end
    endtask

    task automatic test_full();
        logic [7:0] a0, a1;
        step(1'b1, 2'b00, 16'h0, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            a0 = 8'(8'h80 + 2*i);
            a1 = 8'(8'h81 + 2*i);
            step(1'b0, 2'b11, {a1, a0}, 4'h0, 32'h0);
        end
        checks++; if (obs_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", obs_full); end
        checks++; if (obs_occ !== 8) begin failures++; $display("FAIL full_occ got=%0d exp=8", obs_occ); end
        step(1'b0, 2'b11, {8'h99, 8'h80}, 4'h0, 32'h0);
        checks++; if (obs_stall !== 2'b10) begin failures++; $display("FAIL full_new_vs_owner got=%b exp=10", obs_stall); end
        step(1'b0, 2'b10, {8'h99, 8'h00}, 4'b0001, 32'h82);
        checks++; if (obs_stall !== 2'b10) begin failures++; $display("FAIL full_rel_cycle got=%b exp=10", obs_stall); end
        checks++; if (obs_occ !== 7) begin failures++; $display("FAIL full_rel_occ got=%0d exp=7", obs_occ); end
        step(1'b0, 2'b10, {8'h99, 8'h00}, 4'h0, 32'h0);
        checks++; if (obs_stall !== 2'b00) begin failures++; $display("FAIL full_after_free got=%b exp=00", obs_stall); end
        checks++; if (obs_full !== 1'b1) begin failures++; $display("FAIL full_refill got=%b exp=1", obs_full); end
    endtask

    task automatic test_max_count();
        step(1'b1, 2'b00, 16'h0, 4'h0, 32'h0);
        for (int i = 0; i < MC; i++) begin
            step(1'b0, 2'b01, {8'h00, 8'h05}, 4'h0, 32'h0);
            checks++; if (obs_stall !== 2'b00) begin failures++; $display("FAIL max_accept i=%0d got=%b exp=00", i, obs_stall); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 2'b01, {8'h00, 8'h05}, 4'h0, 32'h0);
            checks++; if (obs_stall !== 2'b01) begin failures++; $display("FAIL max_sat i=%0d got=%b exp=01", i, obs_stall); end
        end
        step(1'b0, 2'b01, {8'h00, 8'h05}, 4'b0100, 32'h0005_0000);
        checks++; if (obs_stall !== 2'b01) begin failures++; $display("FAIL max_rel_cycle got=%b exp=01", obs_stall); end
        step(1'b0, 2'b01, {8'h00, 8'h05}, 4'h0, 32'h0);
        checks++; if (obs_stall !== 2'b00) begin failures++; $display("FAIL max_after_rel got=%b exp=00", obs_stall); end
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL max_err got=%b exp=0", obs_err); end
    endtask

    task automatic test_errors();
        step(1'b1, 2'b00, 16'h0, 4'h0, 32'h0);
        step(1'b0, 2'b00, 16'h0, 4'b1000, 32'h7700_0000);
        checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL err_untracked got=%b exp=1", obs_err); end
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 16'h0, 4'h0, 32'h0);
        checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", obs_err); end
        step(1'b1, 2'b00, 16'h0, 4'h0, 32'h0);
        step(1'b0, 2'b10, {8'h33, 8'h00}, 4'h0, 32'h0);
        checks++; if (obs_err !== 1'b0 || obs_occ !== 1) begin failures++; $display("FAIL err_pre err=%b occ=%0d exp err=0 occ=1", obs_err, obs_occ); end
        step(1'b0, 2'b00, 16'h0, 4'b0011, 32'h0000_3333);
        checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL err_underflow got=%b exp=1", obs_err); end
        checks++; if (obs_occ !== 0) begin failures++; $display("FAIL err_freed_occ got=%0d exp=0", obs_occ); end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 2'b11, {8'h21, 8'h20}, 4'h0, 32'h0);
        step(1'b1, 2'b00, 16'h0, 4'h0, 32'h0);
        checks++; if (obs_occ !== 0 || obs_err !== 1'b0) begin failures++; $display("FAIL mid_reset occ=%0d err=%b exp 0/0", obs_occ, obs_err); end
    endtask

    task automatic test_random();
        logic [15:0] sa;
        logic [31:0] ra;
        logic [3:0]  rv;
        logic        r;
        int          keys[$];
        for (int i = 0; i < 400; i++) begin
            keys.delete();
            foreach (m_cnt[a]) keys.push_back(a);
            r = (i % 100 == 0);
            sa[7:0]  = 8'(8'h10 + $urandom_range(0, 11));
            sa[15:8] = 8'(8'h10 + $urandom_range(0, 11));
            rv = 4'($urandom) & 4'($urandom);
            for (int j = 0; j < 4; j++) begin
                if (keys.size() > 0 && $urandom_range(0, 3) != 0)
                    ra[j*8 +: 8] = 8'(keys[$urandom_range(0, keys.size() - 1)]);
                else
                    ra[j*8 +: 8] = 8'(8'h10 + $urandom_range(0, 11));
            end
            step(r, 2'($urandom), sa, rv, ra);
            checks++; if (obs_stall !== exp_stall) begin failures++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", i, obs_stall, exp_stall); end
            checks++; if (obs_occ !== m_cnt.num()) begin failures++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", i, obs_occ, m_cnt.num()); end
            checks++; if (obs_full !== (m_cnt.num() == NE)) begin failures++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", i, obs_full, m_cnt.num() == NE); end
            checks++; if (obs_err !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", i, obs_err, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_owner_conflict();
        test_same_cycle();
        test_full();
        test_max_count();
        test_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
